// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, status bit
// positions, FSM state encoding and a status packing helper.
package alu_pkg;

    // Op codes carried in sel[4:2]
    localparam logic [2:0] OP_ZERO = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_ASR  = 3'd7;

    // Bit positions inside the 4-bit status word {N,O,Z,C}
    localparam int ST_C = 0;
    localparam int ST_Z = 1;
    localparam int ST_O = 2;
    localparam int ST_N = 3;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [3:0] pack_status(input logic n, input logic o,
                                               input logic z, input logic c);
        logic [3:0] s;
        s       = '0;
        s[ST_N] = n;
        s[ST_O] = o;
        s[ST_Z] = z;
        s[ST_C] = c;
        return s;
    endfunction

endpackage

// File: rtl/alu_seq_shift_step.sv
// One iteration of the shifter: shifts by 0..SHIFT_STEP bits, left with
// zero fill or right with a caller-chosen fill bit (logical or arithmetic).
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int SHIFT_STEP = 8,
    parameter int AMT_W      = $clog2(SHIFT_STEP + 1)
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir_left,
    input  logic             fill,
    output logic [WIDTH-1:0] data_out
);

    // Right shifts pull fill bits in from a double-width extension
    always_comb begin
        if (dir_left) begin
            data_out = data_in << amt;
        end else begin
            data_out = WIDTH'({{WIDTH{fill}}, data_in} >> amt);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on both sides. Logic and add
// ops finish in one cycle; shifts iterate SHIFT_STEP bits per cycle.
// Optional macro ALU_ARITH_SHIFT_EN turns op 7 into an arithmetic right
// shift; without it op 7 returns zero in one cycle.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int SHIFT_STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [4:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic [3:0]       status,
    output logic             busy
);

    localparam int AW = $clog2(WIDTH);
    localparam int RW = AW + 1;
    localparam int SW = $clog2(SHIFT_STEP + 1);
    localparam logic [RW-1:0] STEP_V = RW'(SHIFT_STEP);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] work_q,   work_d;
    logic [AW-1:0]    rem_q,    rem_d;
    logic [2:0]       op_q,     op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic [3:0]       status_q, status_d;

    logic [WIDTH-1:0] a_p, b_p, fast_res, shifted;
    logic [WIDTH:0]   sum;
    logic [2:0]       op_in;
    logic [AW-1:0]    n_in;
    logic             fast_cout, fast_ovf, shift_in, xfer;
    logic [RW-1:0]    rem_ext, step_amt, rem_left;
    logic             shift_left, shift_fill;

    // Single-cycle datapath: operand inversion, adder and logic ops
    always_comb begin
        a_p       = sel[0] ? ~a : a;
        b_p       = sel[1] ? ~b : b;
        sum       = {1'b0, a_p} + {1'b0, b_p} + {{WIDTH{1'b0}}, cin};
        op_in     = sel[4:2];
        n_in      = b[AW-1:0];
        fast_res  = '0;
        fast_cout = 1'b0;
        fast_ovf  = 1'b0;
        shift_in  = 1'b0;
        case (op_in)
            OP_OR:  fast_res = a_p | b_p;
            OP_AND: fast_res = a_p & b_p;
            OP_XOR: fast_res = a_p ^ b_p;
            OP_ADD: begin
                fast_res  = sum[WIDTH-1:0];
                fast_cout = sum[WIDTH];
                fast_ovf  = ~(a_p[WIDTH-1] ^ b_p[WIDTH-1]) & (a_p[WIDTH-1] ^ sum[WIDTH-1]);
            end
            // A zero-distance shift completes here and simply returns a
            OP_SHR, OP_SHL: begin
                fast_res = a;
                shift_in = 1'b1;
            end
`ifdef ALU_ARITH_SHIFT_EN
            OP_ASR: begin
                fast_res = a;
                shift_in = 1'b1;
            end
`endif
            default: fast_res = '0;
        endcase
    end

    // Per-cycle shift amount: the smaller of the step size and what is left
    always_comb begin
        rem_ext    = {1'b0, rem_q};
        step_amt   = (rem_ext < STEP_V) ? rem_ext : STEP_V;
        rem_left   = rem_ext - step_amt;
        shift_left = (op_q == OP_SHL);
`ifdef ALU_ARITH_SHIFT_EN
        shift_fill = (op_q == OP_ASR) & work_q[WIDTH-1];
`else
        shift_fill = 1'b0;
`endif
    end

    alu_shift_step #(
        .WIDTH      (WIDTH),
        .SHIFT_STEP (SHIFT_STEP),
        .AMT_W      (SW)
    ) u_shift_step (
        .data_in  (work_q),
        .amt      (step_amt[SW-1:0]),
        .dir_left (shift_left),
        .fill     (shift_fill),
        .data_out (shifted)
    );

    // Handshake, FSM transitions and result/flag loading
    always_comb begin
        in_ready = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
        xfer     = in_valid & in_ready;
        state_d  = state_q;
        work_d   = work_q;
        rem_d    = rem_q;
        op_d     = op_q;
        result_d = result_q;
        cout_d   = cout_q;
        status_d = status_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_BUSY: begin
                    work_d = shifted;
                    rem_d  = rem_left[AW-1:0];
                    if (rem_left == '0) begin
                        state_d  = S_DONE;
                        result_d = shifted;
                        cout_d   = 1'b0;
                        status_d = pack_status(shifted[WIDTH-1], 1'b0, shifted == '0, 1'b0);
                    end
                end
                S_IDLE, S_DONE: begin
                    if (xfer) begin
                        if (shift_in && (n_in != '0)) begin
                            state_d = S_BUSY;
                            work_d  = a;
                            rem_d   = n_in;
                            op_d    = op_in;
                        end else begin
                            state_d  = S_DONE;
                            result_d = fast_res;
                            cout_d   = fast_cout;
                            status_d = pack_status(fast_res[WIDTH-1], fast_ovf,
                                                   fast_res == '0, fast_cout);
                        end
                    end else if ((state_q == S_DONE) && out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; reset clears everything, aborting any shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            op_q     <= OP_ZERO;
            result_q <= '0;
            cout_q   <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            rem_q    <= rem_d;
            op_q     <= op_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            status_q <= status_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign result    = result_q;
    assign cout      = cout_q;
    assign status    = status_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: a transaction-level model predicts handshake, busy,
// result and flags every cycle; directed vectors add literal expectations.
module tb_alu_seq;

    localparam int W    = 64;
    localparam int STEP = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         cin = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [4:0]   sel = '0;
    logic         in_ready, out_valid, cout, busy;
    logic [W-1:0] result;
    logic [3:0]   status;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(W), .SHIFT_STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .status    (status),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [4:0] mk_sel(input int op, input logic inv_b, input logic inv_a);
        logic [2:0] o;
        o = 3'(op);
        return {o, inv_b, inv_a};
    endfunction

    // Reference behaviour: result, carry, flags and number of busy cycles
    function automatic void model_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                     input logic tcin, input logic [4:0] tsel,
                                     output logic [W-1:0] r, output logic co,
                                     output logic [3:0] st, output int lat);
        logic [W-1:0] ap, bp;
        logic [W:0]   s;
        logic         ov;
        int           n;
        ap  = tsel[0] ? ~ta : ta;
        bp  = tsel[1] ? ~tb : tb;
        n   = int'(tb[$clog2(W)-1:0]);
        co  = 1'b0;
        ov  = 1'b0;
        lat = 0;
        r   = '0;
        case (tsel[4:2])
            3'd1: r = ap | bp;
            3'd2: r = ap & bp;
            3'd3: r = ap ^ bp;
            3'd4: begin
                s  = ap + bp + tcin;
                r  = s[W-1:0];
                co = s[W];
                ov = (ap[W-1] == bp[W-1]) && (r[W-1] != ap[W-1]);
            end
            3'd5: begin r = ta >> n; lat = (n + STEP - 1) / STEP; end
            3'd6: begin r = ta << n; lat = (n + STEP - 1) / STEP; end
`ifdef ALU_ARITH_SHIFT_EN
            3'd7: begin r = W'($signed(ta) >>> n); lat = (n + STEP - 1) / STEP; end
`endif
            default: r = '0;
        endcase
        st = {r[W-1], ov, (r == '0), co};
    endfunction

    // Model state: remaining busy cycles, completion flag and held outputs
    logic         m_done = 1'b0;
    int           m_cnt = 0;
    logic [W-1:0] m_res = '0, p_res = '0;
    logic         m_cout = 1'b0, p_cout = 1'b0;
    logic [3:0]   m_stat = '0, p_stat = '0;

    always @(negedge clk) begin
        logic         exp_iready, xfer, co;
        logic [W-1:0] r;
        logic [3:0]   st;
        int           lat;
        if (rst) begin
            m_done = 1'b0; m_cnt = 0; m_res = '0; m_cout = 1'b0; m_stat = '0;
        end
        exp_iready = !flush && ((m_cnt == 0 && !m_done) || (m_done && out_ready));
        check("in_ready", in_ready, exp_iready);
        check("out_valid", out_valid, m_done);
        check("busy", busy, m_cnt > 0);
        check("result", result, m_res);
        check("cout", cout, m_cout);
        check("status", status, m_stat);
        if (!rst) begin
            xfer = in_valid && exp_iready;
            if (flush) begin
                m_cnt = 0; m_done = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1; m_res = p_res; m_cout = p_cout; m_stat = p_stat;
                end
            end else if (xfer) begin
                model_op(a, b, cin, sel, r, co, st, lat);
                if (lat == 0) begin
                    m_done = 1'b1; m_res = r; m_cout = co; m_stat = st;
                end else begin
                    m_done = 1'b0; m_cnt = lat; p_res = r; p_cout = co; p_stat = st;
                end
            end else if (m_done && out_ready) begin
                m_done = 1'b0;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Presents one op and holds it until the transfer edge has passed
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic [4:0] tsel);
        logic got;
        got = 1'b0;
        a = ta; b = tb; cin = tcin; sel = tsel; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("send_accept", got, 1);
        sync();
        in_valid = 1'b0;
    endtask

    initial begin
        int lat, bc;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_status", status, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        sync();
        rst = 1'b0;

        // Add with carry out and zero result
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk_sel(4, 0, 0));
        @(negedge clk);
        check("add_valid", out_valid, 1);
        check("add_result", result, 0);
        check("add_cout", cout, 1);
        check("add_status", status, 4'b0011);

        // Signed overflow
        sync();
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk_sel(4, 0, 0));
        @(negedge clk);
        check("ovf_result", result, 64'h8000_0000_0000_0000);
        check("ovf_status", status, 4'b1100);
        check("ovf_cout", cout, 0);

        // Subtract via inverted b plus carry in
        sync();
        send(64'd5, 64'd5, 1'b1, mk_sel(4, 1, 0));
        @(negedge clk);
        check("sub_result", result, 0);
        check("sub_status", status, 4'b0011);

        // Shift left by 63: 8 busy cycles, valid 9 cycles after transfer
        sync();
        send(64'd1, 64'd63, 1'b0, mk_sel(6, 0, 0));
        lat = 0; bc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("shl_latency", lat, 9);
        check("shl_busy_cycles", bc, 8);
        check("shl_result", result, 64'h8000_0000_0000_0000);
        check("shl_status", status, 4'b1000);

        // Shift right by 0 (upper bits of b ignored): one-cycle passthrough
        sync();
        send(64'hDEAD_BEEF_0123_4567, 64'h40, 1'b0, mk_sel(5, 0, 0));
        @(negedge clk);
        check("shr0_valid", out_valid, 1);
        check("shr0_busy", busy, 0);
        check("shr0_result", result, 64'hDEAD_BEEF_0123_4567);
        check("shr0_status", status, 4'b1000);

        // Back-pressure: result held while the consumer stalls
        sync();
        out_ready = 1'b0;
        send(64'hF0F0, 64'h0F0F, 1'b0, mk_sel(1, 0, 0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_result", result, 64'hFFFF);
        end
        sync();

        // Back-to-back xor/or stream, one result per cycle
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = 64'(k * 17); b = 64'd5; cin = 1'b0;
            sel = (k % 2 == 0) ? mk_sel(3, 0, 0) : mk_sel(1, 0, 0);
            in_valid = 1'b1;
            @(negedge clk);
            check("b2b_valid", out_valid, 1);
            check("b2b_in_ready", in_ready, 1);
            sync();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last", result, 64'h77);

        // Flush during a shift with a competing request
        sync();
        send(64'd3, 64'd40, 1'b0, mk_sel(6, 0, 0));
        sync();
        flush = 1'b1;
        a = 64'd9; b = 64'd9; sel = mk_sel(4, 0, 0); in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        check("flush_busy", busy, 1);
        sync();
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_idle_busy", busy, 0);
        check("flush_idle_ready", in_ready, 1);
        check("flush_kept_result", result, 64'h77);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("flush_no_valid", out_valid, 0);
        end
        sync();
        send(64'd2, 64'd3, 1'b0, mk_sel(4, 0, 0));
        @(negedge clk);
        check("post_flush_result", result, 64'd5);
        check("post_flush_status", status, 4'b0000);

        // Op 7
        sync();
        send(64'h8000_0000_0000_0000, 64'd4, 1'b0, mk_sel(7, 0, 0));
`ifdef ALU_ARITH_SHIFT_EN
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("asr_latency", lat, 2);
        check("asr_result", result, 64'hF800_0000_0000_0000);
        check("asr_status", status, 4'b1000);
`else
        @(negedge clk);
        check("op7_valid", out_valid, 1);
        check("op7_result", result, 0);
        check("op7_status", status, 4'b0010);
`endif

        // Reset in the middle of a shift aborts it silently
        sync();
        send(64'd1, 64'd63, 1'b0, mk_sel(6, 0, 0));
        sync(); sync(); sync();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_result", result, 0);
        check("rst_mid_cout", cout, 0);
        check("rst_mid_status", status, 0);
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        sync();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rst_mid_no_valid", out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
